// File: rtl/bandit_ctrl.sv
// bandit_ctrl: one-armed-bandit game controller.
// Keeps a saturating credit count, runs three decimal reels through a timed
// spin with staggered stops, scores the stopped reels and holds the result
// until the player collects it.
// Optional feature macro: BANDIT_LFSR_EN -- when defined, a free-running
// 16-bit LFSR supplies 0..7 extra spin ticks per game; when undefined the
// extra tick count is 0 and every spin is deterministic.
module bandit_ctrl #(
  parameter int SPIN_DIV   = 5_000_000,
  parameter int SPIN_TICKS = 40,
  parameter int STOP_GAP   = 8,
  parameter int MAX_CREDIT = 99
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       coin_p,
  input  logic       start_p,
  input  logic       score_p,
  output logic [6:0] credit,
  output logic [3:0] reel0,
  output logic [3:0] reel1,
  output logic [3:0] reel2,
  output logic       busy,
  output logic       win,
  output logic [5:0] payout
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SPIN = 2'd1,
    EVAL = 2'd2,
    SHOW = 2'd3
  } state_t;

  localparam int DIV_W = $clog2(SPIN_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(SPIN_DIV - 1);
  localparam logic [7:0]       TICKS_BASE = 8'(SPIN_TICKS);
  localparam logic [7:0]       GAP        = 8'(STOP_GAP);
  localparam logic [6:0]       CRED_MAX   = 7'(MAX_CREDIT);

  // Advance one decimal reel symbol, wrapping 9 back to 0.
  function automatic logic [3:0] digit_inc(input logic [3:0] d);
    digit_inc = (d == 4'd9) ? 4'd0 : d + 4'd1;
  endfunction

  // Score the three stopped reels; the first matching rule wins.
  function automatic logic [5:0] score_reels(input logic [3:0] a,
                                             input logic [3:0] b,
                                             input logic [3:0] c);
    if ((a == b) && (b == c) && (a == 4'd7)) begin
      score_reels = 6'd50;
    end else if ((a == b) && (b == c)) begin
      score_reels = 6'd10;
    end else if ((a == b) || (b == c)) begin
      score_reels = 6'd2;
    end else begin
      score_reels = 6'd0;
    end
  endfunction

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [7:0]       tick_q, tick_d;
  logic [2:0]       extra_q, extra_d;
  logic [6:0]       credit_q, credit_d;
  logic [3:0]       reel0_q, reel0_d;
  logic [3:0]       reel1_q, reel1_d;
  logic [3:0]       reel2_q, reel2_d;
  logic             busy_q, busy_d;
  logic             win_q, win_d;
  logic [5:0]       payout_q, payout_d;

  logic [2:0] extra_s;
  logic [7:0] tick_next_s;
  logic [7:0] stop0_s;
  logic [7:0] stop1_s;
  logic [7:0] stop2_s;
  logic [7:0] collect_sum_s;
  logic [5:0] score_s;

`ifdef BANDIT_LFSR_EN
  logic [15:0] lfsr_q;

  // Fibonacci LFSR (taps 16,14,13,11) free-running in every state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= 16'hACE1;
    end else begin
      lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end
  end

  assign extra_s = lfsr_q[2:0];
`else
  assign extra_s = 3'd0;
`endif

  // Stop points are measured in ticks from SPIN entry; reel n stops n gaps after reel 0.
  assign tick_next_s   = tick_q + 8'd1;
  assign stop0_s       = TICKS_BASE + {5'd0, extra_q};
  assign stop1_s       = stop0_s + GAP;
  assign stop2_s       = stop1_s + GAP;
  // Worst case 127 + 63 + 1 fits in 8 bits, so the sum never wraps.
  assign collect_sum_s = {1'b0, credit_q} + {2'd0, payout_q} + {7'd0, coin_p};
  assign score_s       = score_reels(reel0_q, reel1_q, reel2_q);

  // State and datapath registers; every output is taken straight from here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      div_q    <= '0;
      tick_q   <= 8'd0;
      extra_q  <= 3'd0;
      credit_q <= 7'd0;
      reel0_q  <= 4'd0;
      reel1_q  <= 4'd0;
      reel2_q  <= 4'd0;
      busy_q   <= 1'b0;
      win_q    <= 1'b0;
      payout_q <= 6'd0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      tick_q   <= tick_d;
      extra_q  <= extra_d;
      credit_q <= credit_d;
      reel0_q  <= reel0_d;
      reel1_q  <= reel1_d;
      reel2_q  <= reel2_d;
      busy_q   <= busy_d;
      win_q    <= win_d;
      payout_q <= payout_d;
    end
  end

  // Next-state logic: coin credit, game sequencing, reel stepping and scoring.
  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    tick_d   = tick_q;
    extra_d  = extra_q;
    reel0_d  = reel0_q;
    reel1_d  = reel1_q;
    reel2_d  = reel2_q;
    win_d    = win_q;
    payout_d = payout_q;

    // A coin adds one credit in any state; specific states override below.
    if (coin_p) begin
      credit_d = (credit_q >= CRED_MAX) ? CRED_MAX : credit_q + 7'd1;
    end else begin
      credit_d = credit_q;
    end

    case (state_q)
      IDLE: begin
        // Credit is judged before any same-cycle coin is added.
        if (start_p && (credit_q != 7'd0)) begin
          credit_d = coin_p ? credit_q : credit_q - 7'd1;
          div_d    = '0;
          tick_d   = 8'd0;
          extra_d  = extra_s;
          state_d  = SPIN;
        end else begin
          state_d  = IDLE;
        end
      end
      SPIN: begin
        if (div_q == DIV_LAST) begin
          div_d  = '0;
          tick_d = tick_next_s;
          if (tick_next_s <= stop0_s) begin
            reel0_d = digit_inc(reel0_q);
          end else begin
            reel0_d = reel0_q;
          end
          if (tick_next_s <= stop1_s) begin
            reel1_d = digit_inc(reel1_q);
          end else begin
            reel1_d = reel1_q;
          end
          if (tick_next_s <= stop2_s) begin
            reel2_d = digit_inc(reel2_q);
          end else begin
            reel2_d = reel2_q;
          end
          if (tick_next_s == stop2_s) begin
            state_d = EVAL;
          end else begin
            state_d = SPIN;
          end
        end else begin
          div_d = div_q + {{(DIV_W-1){1'b0}}, 1'b1};
        end
      end
      EVAL: begin
        payout_d = score_s;
        win_d    = (score_s != 6'd0);
        state_d  = SHOW;
      end
      SHOW: begin
        if (score_p) begin
          credit_d = (collect_sum_s > {1'b0, CRED_MAX}) ? CRED_MAX : collect_sum_s[6:0];
          payout_d = 6'd0;
          win_d    = 1'b0;
          state_d  = IDLE;
        end else begin
          state_d  = SHOW;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == SPIN) || (state_d == EVAL);
  end

  assign credit = credit_q;
  assign reel0  = reel0_q;
  assign reel1  = reel1_q;
  assign reel2  = reel2_q;
  assign busy   = busy_q;
  assign win    = win_q;
  assign payout = payout_q;

endmodule

// File: tb/tb_bandit_ctrl.sv
// Directed bench for bandit_ctrl. Three instances with short tick divisors
// and different stop spacing share clock and reset; each has its own pulses.
//   u[0]: SPIN_TICKS=12, STOP_GAP=3  -> 0/0/0 spins to 2/5/8, payout 0
//   u[1]: SPIN_TICKS=12, STOP_GAP=10 -> 0/0/0 spins to 2/2/2, payout 10
//   u[2]: SPIN_TICKS=17, STOP_GAP=10 -> 0/0/0 spins to 7/7/7, payout 50
module tb_bandit_ctrl;

  logic       clk;
  logic       rst_n;
  logic [2:0] coin;
  logic [2:0] start;
  logic [2:0] score;
  logic [6:0] credit_w [3];
  logic [3:0] r0_w [3];
  logic [3:0] r1_w [3];
  logic [3:0] r2_w [3];
  logic [2:0] busy_w;
  logic [2:0] win_w;
  logic [5:0] payout_w [3];

  int checks;
  int failures;

  genvar g;
  generate
    for (g = 0; g < 3; g++) begin : gen_dut
      bandit_ctrl #(
        .SPIN_DIV  (2),
        .SPIN_TICKS((g == 2) ? 17 : 12),
        .STOP_GAP  ((g == 0) ? 3 : 10),
        .MAX_CREDIT(99)
      ) u_dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .coin_p (coin[g]),
        .start_p(start[g]),
        .score_p(score[g]),
        .credit (credit_w[g]),
        .reel0  (r0_w[g]),
        .reel1  (r1_w[g]),
        .reel2  (r2_w[g]),
        .busy   (busy_w[g]),
        .win    (win_w[g]),
        .payout (payout_w[g])
      );
    end
  endgenerate

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One-cycle pulse on the chosen inputs of instance idx; returns at the
  // falling edge after the sampling edge, so results are already visible.
  task automatic pulse(input int idx, input bit c, input bit s, input bit k);
    @(negedge clk);
    coin[idx]  = c;
    start[idx] = s;
    score[idx] = k;
    @(negedge clk);
    coin[idx]  = 1'b0;
    start[idx] = 1'b0;
    score[idx] = 1'b0;
  endtask

  // Wait (bounded) for instance idx to leave SPIN/EVAL; returns busy cycles.
  task automatic wait_done(input int idx, input string tag, output int n);
    n = 0;
    while (busy_w[idx] && (n < 300)) begin
      n++;
      @(negedge clk);
    end
    check_eq({tag, "_done"}, int'(busy_w[idx]), 0);
  endtask

  task automatic check_show(input int idx, input string tag,
                            input int e0, input int e1, input int e2,
                            input int ep, input int ew);
    check_eq({tag, "_reel0"}, int'(r0_w[idx]), e0);
    check_eq({tag, "_reel1"}, int'(r1_w[idx]), e1);
    check_eq({tag, "_reel2"}, int'(r2_w[idx]), e2);
    check_eq({tag, "_payout"}, int'(payout_w[idx]), ep);
    check_eq({tag, "_win"}, int'(win_w[idx]), ew);
  endtask

  initial begin
    int n;
    checks   = 0;
    failures = 0;
    coin     = 3'b000;
    start    = 3'b000;
    score    = 3'b000;
    rst_n    = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Reset values.
    for (int i = 0; i < 3; i++) begin
      check_eq("rst_credit", int'(credit_w[i]), 0);
      check_eq("rst_busy", int'(busy_w[i]), 0);
      check_show(i, "rst", 0, 0, 0, 0, 0);
    end

    // Start with no credit is ignored.
    pulse(0, 1'b0, 1'b1, 1'b0);
    check_eq("nocred_credit", int'(credit_w[0]), 0);
    check_eq("nocred_busy", int'(busy_w[0]), 0);
    @(negedge clk);
    check_eq("nocred_busy_later", int'(busy_w[0]), 0);

    // First coin.
    pulse(0, 1'b1, 1'b0, 1'b0);
    check_eq("coin1_credit", int'(credit_w[0]), 1);

    // u[0] spin: 18 ticks x 2 cycles + 1 EVAL cycle of busy.
    pulse(0, 1'b0, 1'b1, 1'b0);
    check_eq("spin0_busy", int'(busy_w[0]), 1);
    check_eq("spin0_credit", int'(credit_w[0]), 0);
    wait_done(0, "spin0", n);
    check_eq("spin0_busy_cycles", n, 37);
    check_show(0, "spin0", 2, 5, 8, 0, 0);
    check_eq("spin0_credit_show", int'(credit_w[0]), 0);

    // Saturation: 120 coins from 0 stop at 99 (coins count in SHOW too).
    for (int i = 0; i < 120; i++) pulse(0, 1'b1, 1'b0, 1'b0);
    check_eq("sat_credit", int'(credit_w[0]), 99);

    // Start in SHOW is ignored; zero-payout collect leaves credit alone.
    pulse(0, 1'b0, 1'b1, 1'b0);
    check_eq("show_start_credit", int'(credit_w[0]), 99);
    check_eq("show_start_busy", int'(busy_w[0]), 0);
    pulse(0, 1'b0, 1'b0, 1'b1);
    check_eq("collect0_credit", int'(credit_w[0]), 99);
    // Back in IDLE: start is accepted now.
    pulse(0, 1'b0, 1'b1, 1'b0);
    check_eq("restart0_busy", int'(busy_w[0]), 1);
    check_eq("restart0_credit", int'(credit_w[0]), 98);

    // u[2]: start with zero credit plus same-cycle coin -> coin only.
    pulse(2, 1'b1, 1'b1, 1'b0);
    check_eq("cs0_credit", int'(credit_w[2]), 1);
    check_eq("cs0_busy", int'(busy_w[2]), 0);
    pulse(2, 1'b0, 1'b1, 1'b0);
    check_eq("spin2_busy", int'(busy_w[2]), 1);
    wait_done(2, "spin2", n);
    check_show(2, "spin2", 7, 7, 7, 50, 1);
    for (int i = 0; i < 60; i++) pulse(2, 1'b1, 1'b0, 1'b0);
    check_eq("pre_collect2_credit", int'(credit_w[2]), 60);
    // Score with coin: min(60+50+1, 99).
    pulse(2, 1'b1, 1'b0, 1'b1);
    check_eq("collect2_credit", int'(credit_w[2]), 99);
    check_eq("collect2_payout", int'(payout_w[2]), 0);
    check_eq("collect2_win", int'(win_w[2]), 0);

    // u[1]: score outside SHOW ignored, then triple-match spin.
    pulse(1, 1'b1, 1'b0, 1'b0);
    pulse(1, 1'b0, 1'b0, 1'b1);
    check_eq("idle_score_credit", int'(credit_w[1]), 1);
    pulse(1, 1'b0, 1'b1, 1'b0);
    wait_done(1, "spin1", n);
    check_show(1, "spin1", 2, 2, 2, 10, 1);
    check_eq("spin1_credit", int'(credit_w[1]), 0);
    pulse(1, 1'b0, 1'b0, 1'b1);
    check_eq("collect1_credit", int'(credit_w[1]), 10);
    check_eq("collect1_busy", int'(busy_w[1]), 0);
    check_eq("collect1_win", int'(win_w[1]), 0);

    // Same-cycle coin and accepted start: net zero.
    pulse(1, 1'b1, 1'b1, 1'b0);
    check_eq("cs_credit", int'(credit_w[1]), 10);
    check_eq("cs_busy", int'(busy_w[1]), 1);

    // Reset mid-spin.
    repeat (5) @(negedge clk);
    check_eq("midspin_busy", int'(busy_w[1]), 1);
    rst_n = 1'b0;
    #1;
    check_eq("midrst_credit", int'(credit_w[1]), 0);
    check_eq("midrst_busy", int'(busy_w[1]), 0);
    check_show(1, "midrst", 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // A normal spin after the reset.
    pulse(1, 1'b1, 1'b0, 1'b0);
    check_eq("post_coin", int'(credit_w[1]), 1);
    pulse(1, 1'b0, 1'b1, 1'b0);
    check_eq("post_busy", int'(busy_w[1]), 1);
    wait_done(1, "post", n);
    check_eq("post_busy_cycles", n, 65);
    check_show(1, "post", 2, 2, 2, 10, 1);
    check_eq("post_credit", int'(credit_w[1]), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
